// File: rtl/e203_tcm_nport_ctrl.sv
// rtl/e203_tcm_nport_ctrl.sv - N-port ICB arbiter and in-order response buffer for a 1-cycle SRAM TCM
module e203_tcm_nport_ctrl #(
    parameter int NPORT     = 2,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int MW        = DW / 8,
    parameter int AW_LSB    = 2,
    parameter int RAM_DEPTH = 16384,
    parameter int OUTS      = 2,
    parameter int ARB_RR    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         icb_cmd_valid,
    output logic [NPORT-1:0]         icb_cmd_ready,
    input  logic [NPORT*AW-1:0]      icb_cmd_addr,
    input  logic [NPORT-1:0]         icb_cmd_read,
    input  logic [NPORT*DW-1:0]      icb_cmd_wdata,
    input  logic [NPORT*MW-1:0]      icb_cmd_wmask,
    output logic [NPORT-1:0]         icb_rsp_valid,
    input  logic [NPORT-1:0]         icb_rsp_ready,
    output logic [NPORT-1:0]         icb_rsp_err,
    output logic [NPORT*DW-1:0]      icb_rsp_rdata,
    output logic                     ram_cs,
    output logic                     ram_we,
    output logic [AW-AW_LSB-1:0]     ram_addr,
    output logic [MW-1:0]            ram_wem,
    output logic [DW-1:0]            ram_din,
    input  logic [DW-1:0]            ram_dout,
    output logic                     tcm_active
);

    localparam int RAM_AW = AW - AW_LSB;
    localparam int IDW    = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW     = $clog2(OUTS + 1);
    localparam int PW     = (OUTS > 1) ? $clog2(OUTS) : 1;

    logic [CW-1:0]     cnt;
    logic [IDW-1:0]    last;
    logic              gnt_found;
    logic [IDW-1:0]    gnt_id;
    logic [IDW-1:0]    cand;
    int                rr_idx;
    logic              can_accept;
    logic              cmd_hs;

    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [MW-1:0]     sel_wmask;
    logic              sel_read;
    logic [RAM_AW-1:0] sel_waddr;
    logic              sel_err;

    logic              p1_valid;
    logic [IDW-1:0]    p1_id;
    logic              p1_read;
    logic              p1_err;
    logic [DW-1:0]     p1_rdata;

    logic [IDW-1:0]    buf_id    [OUTS];
    logic              buf_err   [OUTS];
    logic [DW-1:0]     buf_rdata [OUTS];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     buf_cnt;
    logic              buf_empty;
    logic              buf_push;
    logic              buf_pop;

    logic              head_valid;
    logic [IDW-1:0]    head_id;
    logic              head_err;
    logic [DW-1:0]     head_rdata;
    logic              rsp_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Fixed priority scans 0..NPORT-1; round-robin scans starting just after the last winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        rr_idx    = 0;
        cand      = '0;
        for (int k = 1; k <= NPORT; k++) begin
            if (ARB_RR != 0) begin
                rr_idx = int'(last) + k;
                if (rr_idx >= NPORT) begin
                    rr_idx = rr_idx - NPORT;
                end
            end else begin
                rr_idx = k - 1;
            end
            cand = IDW'(rr_idx);
            if (!gnt_found && icb_cmd_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign can_accept = (cnt < CW'(OUTS));
    assign cmd_hs     = gnt_found & can_accept;

    always_comb begin
        icb_cmd_ready = '0;
        sel_addr      = icb_cmd_addr[AW-1:0];
        sel_wdata     = icb_cmd_wdata[DW-1:0];
        sel_wmask     = icb_cmd_wmask[MW-1:0];
        sel_read      = icb_cmd_read[0];
        for (int i = 0; i < NPORT; i++) begin
            if (gnt_id == IDW'(i)) begin
                icb_cmd_ready[i] = cmd_hs;
                sel_addr         = icb_cmd_addr[i*AW +: AW];
                sel_wdata        = icb_cmd_wdata[i*DW +: DW];
                sel_wmask        = icb_cmd_wmask[i*MW +: MW];
                sel_read         = icb_cmd_read[i];
            end
        end
    end

    assign sel_waddr = sel_addr[AW-1:AW_LSB];
    assign sel_err   = (64'(sel_waddr) >= 64'(RAM_DEPTH));

    // Gated by rst so a command presented during reset cannot corrupt the SRAM.
    assign ram_cs   = cmd_hs & ~sel_err & ~rst;
    assign ram_we   = ram_cs & ~sel_read;
    assign ram_wem  = ram_we ? sel_wmask : '0;
    assign ram_addr = sel_waddr;
    assign ram_din  = sel_wdata;

    assign p1_rdata = (p1_read & ~p1_err) ? ram_dout : '0;

    // The oldest response is the buffer head; an empty buffer lets the SRAM result bypass it.
    assign buf_empty  = (buf_cnt == '0);
    assign head_valid = ~buf_empty | p1_valid;
    assign head_id    = buf_empty ? p1_id    : buf_id[rd_ptr];
    assign head_err   = buf_empty ? p1_err   : buf_err[rd_ptr];
    assign head_rdata = buf_empty ? p1_rdata : buf_rdata[rd_ptr];
    assign rsp_hs     = head_valid & icb_rsp_ready[head_id];
    assign buf_push   = p1_valid & (~buf_empty | ~icb_rsp_ready[p1_id]);
    assign buf_pop    = ~buf_empty & rsp_hs;

    always_comb begin
        icb_rsp_valid = '0;
        icb_rsp_err   = '0;
        icb_rsp_rdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (head_valid && (head_id == IDW'(i))) begin
                icb_rsp_valid[i]         = 1'b1;
                icb_rsp_err[i]           = head_err;
                icb_rsp_rdata[i*DW +: DW] = head_rdata;
            end
        end
    end

    assign tcm_active = (|icb_cmd_valid) | (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            last     <= IDW'(NPORT - 1);
            p1_valid <= 1'b0;
            p1_id    <= '0;
            p1_read  <= 1'b0;
            p1_err   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            buf_cnt  <= '0;
        end else begin
            if (cmd_hs && !rsp_hs) begin
                cnt <= cnt + CW'(1);
            end else if (!cmd_hs && rsp_hs) begin
                cnt <= cnt - CW'(1);
            end
            if (cmd_hs) begin
                last <= gnt_id;
            end
            p1_valid <= cmd_hs;
            p1_id    <= gnt_id;
            p1_read  <= sel_read;
            p1_err   <= sel_err;
            if (buf_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (buf_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (buf_push && !buf_pop) begin
                buf_cnt <= buf_cnt + CW'(1);
            end else if (!buf_push && buf_pop) begin
                buf_cnt <= buf_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_push) begin
            buf_id[wr_ptr]    <= p1_id;
            buf_err[wr_ptr]   <= p1_err;
            buf_rdata[wr_ptr] <= p1_rdata;
        end
    end

endmodule

// File: tb/tb_e203_tcm_nport_ctrl.sv
// tb/tb_e203_tcm_nport_ctrl.sv - scoreboard bench for fixed-priority and round-robin controller instances
module tb_e203_tcm_nport_ctrl;

    localparam int NP    = 4;
    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int OUTS  = 2;
    localparam int DEPTH = 16384;
    localparam int RAW   = AW - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]    cmd_valid, cmd_read, rsp_ready;
    logic [NP*AW-1:0] cmd_addr;
    logic [NP*DW-1:0] cmd_wdata;
    logic [NP*MW-1:0] cmd_wmask;

    logic [NP-1:0]    fp_cmd_ready, fp_rsp_valid, fp_rsp_err;
    logic [NP*DW-1:0] fp_rsp_rdata;
    logic             fp_cs, fp_we, fp_active;
    logic [RAW-1:0]   fp_addr;
    logic [MW-1:0]    fp_wem;
    logic [DW-1:0]    fp_din, fp_dout;

    logic [NP-1:0]    rr_cmd_ready, rr_rsp_valid, rr_rsp_err;
    logic [NP*DW-1:0] rr_rsp_rdata;
    logic             rr_cs, rr_we, rr_active;
    logic [RAW-1:0]   rr_addr;
    logic [MW-1:0]    rr_wem;
    logic [DW-1:0]    rr_din, rr_dout;

    e203_tcm_nport_ctrl #(.NPORT(NP), .AW(AW), .DW(DW), .MW(MW), .AW_LSB(2),
        .RAM_DEPTH(DEPTH), .OUTS(OUTS), .ARB_RR(0)) u_fp (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(fp_cmd_ready), .icb_cmd_addr(cmd_addr),
        .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
        .icb_rsp_valid(fp_rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(fp_rsp_err),
        .icb_rsp_rdata(fp_rsp_rdata), .ram_cs(fp_cs), .ram_we(fp_we), .ram_addr(fp_addr),
        .ram_wem(fp_wem), .ram_din(fp_din), .ram_dout(fp_dout), .tcm_active(fp_active)
    );

    e203_tcm_nport_ctrl #(.NPORT(NP), .AW(AW), .DW(DW), .MW(MW), .AW_LSB(2),
        .RAM_DEPTH(DEPTH), .OUTS(OUTS), .ARB_RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(rr_cmd_ready), .icb_cmd_addr(cmd_addr),
        .icb_cmd_read(cmd_read), .icb_cmd_wdata(cmd_wdata), .icb_cmd_wmask(cmd_wmask),
        .icb_rsp_valid(rr_rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_err(rr_rsp_err),
        .icb_rsp_rdata(rr_rsp_rdata), .ram_cs(rr_cs), .ram_we(rr_we), .ram_addr(rr_addr),
        .ram_wem(rr_wem), .ram_din(rr_din), .ram_dout(rr_dout), .tcm_active(rr_active)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hDEADBEEF;
        if (i == 32) return 32'h0;
        return {16'(i) ^ 16'h5A5A, 16'(i)};
    endfunction

    logic [31:0] mem_fp  [DEPTH];
    logic [31:0] mem_rr  [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    bit mem_init = 1'b0;
    bit ref_init = 1'b0;

    // SRAM models: read-first, one cycle read latency.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_fp[i] = init_word(i);
                mem_rr[i] = init_word(i);
            end
            mem_init = 1'b1;
        end
        if (fp_cs) begin
            fp_dout <= mem_fp[fp_addr[13:0]];
            if (fp_we)
                for (int b = 0; b < MW; b++)
                    if (fp_wem[b]) mem_fp[fp_addr[13:0]][b*8 +: 8] = fp_din[b*8 +: 8];
        end
        if (rr_cs) begin
            rr_dout <= mem_rr[rr_addr[13:0]];
            if (rr_we)
                for (int b = 0; b < MW; b++)
                    if (rr_wem[b]) mem_rr[rr_addr[13:0]][b*8 +: 8] = rr_din[b*8 +: 8];
        end
    end

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_fp[$];
    exp_t sb_rr[$];
    exp_t e_fp, e_rr;
    logic [AW-1:0] wa;

    function automatic exp_t mk_exp(input int p);
        exp_t e;
        logic [AW-1:0] a;
        a       = cmd_addr[p*AW +: AW];
        e.port  = p;
        e.err   = ((a >> 2) >= AW'(DEPTH));
        e.rdata = (cmd_read[p] && !e.err) ? ref_mem[a[15:2]] : 32'h0;
        return e;
    endfunction

    // Command handshakes push expectations; response handshakes pop and compare.
    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                if (cmd_valid[p] && fp_cmd_ready[p]) sb_fp.push_back(mk_exp(p));
                if (cmd_valid[p] && rr_cmd_ready[p]) sb_rr.push_back(mk_exp(p));
            end
            for (int p = 0; p < NP; p++) begin
                if (cmd_valid[p] && fp_cmd_ready[p] && !cmd_read[p]) begin
                    wa = cmd_addr[p*AW +: AW];
                    if ((wa >> 2) < AW'(DEPTH))
                        for (int b = 0; b < MW; b++)
                            if (cmd_wmask[p*MW + b])
                                ref_mem[wa[15:2]][b*8 +: 8] = cmd_wdata[p*DW + b*8 +: 8];
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (fp_rsp_valid[p] && rsp_ready[p]) begin
                    if (sb_fp.size() == 0) chk("fp_sb_underflow", 64'(1), 64'(0));
                    else begin
                        e_fp = sb_fp.pop_front();
                        chk("fp_rsp_port", 64'(p), 64'(e_fp.port));
                        chk("fp_rsp_err", 64'(fp_rsp_err[p]), 64'(e_fp.err));
                        chk("fp_rsp_rdata", 64'(fp_rsp_rdata[p*DW +: DW]), 64'(e_fp.rdata));
                    end
                end
                if (rr_rsp_valid[p] && rsp_ready[p]) begin
                    if (sb_rr.size() == 0) chk("rr_sb_underflow", 64'(1), 64'(0));
                    else begin
                        e_rr = sb_rr.pop_front();
                        chk("rr_rsp_port", 64'(p), 64'(e_rr.port));
                        chk("rr_rsp_err", 64'(rr_rsp_err[p]), 64'(e_rr.err));
                        chk("rr_rsp_rdata", 64'(rr_rsp_rdata[p*DW +: DW]), 64'(e_rr.rdata));
                    end
                end
            end
        end
    end

    task automatic drive(input int p, input bit rd, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
        cmd_valid[p]           = 1'b1;
        cmd_read[p]            = rd;
        cmd_addr[p*AW +: AW]   = a;
        cmd_wdata[p*DW +: DW]  = wd;
        cmd_wmask[p*MW +: MW]  = wm;
    endtask

    // Called just after a rising edge; returns just after the edge that completed the handshake.
    task automatic issue(input int p, input bit rd, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
        bit ok;
        ok = 1'b0;
        drive(p, rd, a, wd, wm);
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = fp_cmd_ready[p];
        end
        if (!ok) chk("issue_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1 cmd_valid[p] = 1'b0;
    endtask

    task automatic reset_dut();
        cmd_valid = '0;
        rst = 1'b1;
        sb_fp.delete();
        sb_rr.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit ok;
        logic [3:0] exp_g;
        cmd_valid = '0; cmd_read = '0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        #1 drive(3, 1'b1, 18'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst_ready_fp", 64'(fp_cmd_ready), 64'(4'b1000));
        chk("rst_ready_rr", 64'(rr_cmd_ready), 64'(4'b1000));
        chk("rst_ram_cs", 64'({fp_cs, rr_cs}), 64'(0));
        chk("rst_rsp_valid", 64'({fp_rsp_valid, rr_rsp_valid}), 64'(0));
        chk("rst_rsp_err", 64'({fp_rsp_err, rr_rsp_err}), 64'(0));
        chk("rst_rsp_rdata", 64'(fp_rsp_rdata | rr_rsp_rdata), 64'(0));
        @(posedge clk);
        #1 cmd_valid = '0; rst = 1'b0;
        @(negedge clk);
        chk("idle_active", 64'({fp_active, rr_active}), 64'(0));

        // Single read of word 0x10.
        @(posedge clk);
        #1 drive(0, 1'b1, 18'h40, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_ready", 64'(fp_cmd_ready), 64'(4'b0001));
        chk("rd_cs_we", 64'({fp_cs, fp_we, rr_cs, rr_we}), 64'(4'b1010));
        chk("rd_ram_addr", 64'(fp_addr), 64'(16'h10));
        @(posedge clk);
        #1 cmd_valid = '0;
        @(negedge clk);
        chk("rd_latency_fp", 64'(fp_rsp_valid), 64'(4'b0001));
        chk("rd_latency_rr", 64'(rr_rsp_valid), 64'(4'b0001));
        chk("rd_data", 64'(fp_rsp_rdata[31:0]), 64'(32'hDEADBEEF));

        // Masked write then read back on port 1.
        @(posedge clk);
        #1 issue(1, 1'b0, 18'h80, 32'h11223344, 4'b0101);
        issue(1, 1'b1, 18'h80, 32'h0, 4'h0);
        @(negedge clk);
        chk("wr_mem_fp", 64'(mem_fp[32]), 64'(32'h00220044));
        chk("wr_mem_rr", 64'(mem_rr[32]), 64'(32'h00220044));

        // All ports contending from a fresh reset.
        @(posedge clk);
        #1 reset_dut();
        for (int p = 0; p < NP; p++) drive(p, 1'b1, AW'((32'h100 + p) * 4), 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_g = 4'(1 << (k % 4));
            chk("grant_fp", 64'(fp_cmd_ready), 64'(4'b0001));
            chk("grant_rr", 64'(rr_cmd_ready), 64'(exp_g));
        end
        @(posedge clk);
        #1 cmd_valid = '0;
        repeat (3) @(posedge clk);

        // Backpressure: two outstanding reads fill the controller.
        #1 rsp_ready = '0;
        issue(0, 1'b1, 18'hC0, 32'h0, 4'h0);
        issue(0, 1'b1, 18'hC4, 32'h0, 4'h0);
        drive(0, 1'b1, 18'hC8, 32'h0, 4'h0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 64'({fp_cmd_ready[0], rr_cmd_ready[0]}), 64'(0));
            chk("bp_hold_valid", 64'(fp_rsp_valid), 64'(4'b0001));
            chk("bp_hold_rdata", 64'(fp_rsp_rdata[31:0]), 64'(init_word(32'h30)));
        end
        @(posedge clk);
        #1 rsp_ready = '1;
        @(negedge clk);
        chk("full_ready", 64'({fp_cmd_ready[0], rr_cmd_ready[0]}), 64'(0));
        ok = 1'b0;
        for (int n = 0; n < 10 && !ok; n++) begin
            if (n > 0) @(negedge clk);
            ok = fp_cmd_ready[0];
        end
        chk("bp_third_accept", 64'(ok), 64'(1));
        @(posedge clk);
        #1 cmd_valid = '0;
        repeat (3) @(posedge clk);

        // Out-of-range read on port 2.
        #1 drive(2, 1'b1, 18'h10000, 32'h0, 4'h0);
        @(negedge clk);
        chk("oor_ready", 64'(fp_cmd_ready), 64'(4'b0100));
        chk("oor_ram_cs", 64'({fp_cs, rr_cs}), 64'(0));
        @(posedge clk);
        #1 cmd_valid = '0;
        @(negedge clk);
        chk("oor_valid", 64'(fp_rsp_valid), 64'(4'b0100));
        chk("oor_err", 64'(fp_rsp_err), 64'(4'b0100));
        chk("oor_rdata", 64'(fp_rsp_rdata), 64'(0));

        // Reset with two transactions in flight.
        @(posedge clk);
        #1 rsp_ready = '0;
        issue(0, 1'b1, 18'h40, 32'h0, 4'h0);
        issue(0, 1'b1, 18'h44, 32'h0, 4'h0);
        @(negedge clk);
        chk("mid_active", 64'({fp_active, rr_active}), 64'(2'b11));
        rst = 1'b1;
        sb_fp.delete();
        sb_rr.delete();
        #1;
        chk("mid_rst_valid", 64'({fp_rsp_valid, rr_rsp_valid}), 64'(0));
        chk("mid_rst_cnt", 64'({fp_active, rr_active}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0; rsp_ready = '1;
        drive(3, 1'b1, 18'h40, 32'h0, 4'h0);
        @(negedge clk);
        chk("post_rst_ready", 64'(fp_cmd_ready), 64'(4'b1000));
        @(posedge clk);
        #1 cmd_valid = '0;
        @(negedge clk);
        chk("post_rst_latency", 64'({fp_rsp_valid, rr_rsp_valid}), 64'(8'b1000_1000));
        chk("post_rst_rdata", 64'(fp_rsp_rdata[3*DW +: DW]), 64'(32'hDEADBEEF));

        repeat (5) @(negedge clk);
        chk("sb_fp_drained", 64'(sb_fp.size()), 64'(0));
        chk("sb_rr_drained", 64'(sb_rr.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
